// File: rtl/icache.sv
// Direct-mapped read-only instruction cache in front of mem_ctrl.
// Hits answer in one cycle; misses fill a whole line, then answer.
module icache #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    input  logic        if_flush,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_inst,
    output logic        mc_req_valid,
    output logic [31:0] mc_req_addr,
    input  logic        mc_req_ready,
    input  logic        mc_rsp_valid,
    input  logic [31:0] mc_rsp_data
);

    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam logic [WOFF_W-1:0] LAST = WOFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        RESP
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [31:0]        addr_q, addr_d;
    logic [WOFF_W-1:0]  cnt_q, cnt_d;
    logic               squash_q, squash_d;
    logic               ready_q, ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_inst_q, rsp_inst_d;
    logic               mcv_q, mcv_d;
    logic [31:0]        mca_q, mca_d;

    logic [TAG_W-1:0]   tag_q  [NUM_LINES];
    logic [31:0]        data_q [NUM_LINES*LINE_WORDS];

    logic [IDX_W-1:0]   req_idx, lat_idx;
    logic [TAG_W-1:0]   req_tag, lat_tag;
    logic [WOFF_W-1:0]  req_woff, lat_woff;
    logic               hit, accept, fill_we, last;
    logic               unused;

    assign req_idx  = if_req_addr[OFF_W +: IDX_W];
    assign req_tag  = if_req_addr[31 -: TAG_W];
    assign req_woff = if_req_addr[2 +: WOFF_W];
    assign lat_idx  = addr_q[OFF_W +: IDX_W];
    assign lat_tag  = addr_q[31 -: TAG_W];
    assign lat_woff = addr_q[2 +: WOFF_W];
    assign unused   = ^{if_req_addr[1:0], addr_q[1:0]};

    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign accept  = if_req_valid && ready_q && rdy_in && !if_flush;
    assign fill_we = rdy_in && (state_q == FILL) && mc_rsp_valid;
    assign last    = (cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        squash_d    = squash_q;
        ready_d     = ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_inst_d  = rsp_inst_q;
        mcv_d       = mcv_q;
        mca_d       = mca_q;
        if (rdy_in) begin
            rsp_valid_d = 1'b0;
            unique case (state_q)
                IDLE: begin
                    squash_d = 1'b0;
                    if (accept) begin
                        addr_d = if_req_addr;
                        if (hit) begin
                            rsp_valid_d = 1'b1;
                            rsp_inst_d  = data_q[{req_idx, req_woff}];
                        end else begin
                            state_d = REQ;
                            mca_d   = {req_tag, req_idx, OFF_W'(0)};
                        end
                    end
                end
                REQ: begin
                    if (mc_req_ready) begin
                        state_d  = FILL;
                        cnt_d    = '0;
                        squash_d = if_flush;
                    end else if (if_flush) begin
                        state_d = IDLE;
                    end
                end
                FILL: begin
                    squash_d = squash_q || if_flush;
                    if (mc_rsp_valid) begin
                        if (last) begin
                            state_d          = RESP;
                            valid_d[lat_idx] = 1'b1;
                            rsp_valid_d      = !(squash_q || if_flush);
                            // final beat is not in the array yet
                            rsp_inst_d = (lat_woff == cnt_q) ? mc_rsp_data
                                       : data_q[{lat_idx, lat_woff}];
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                RESP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
            ready_d = (state_d == IDLE);
            mcv_d   = (state_d == REQ);
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            addr_q      <= '0;
            cnt_q       <= '0;
            squash_q    <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_inst_q  <= '0;
            mcv_q       <= 1'b0;
            mca_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            squash_q    <= squash_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_inst_q  <= rsp_inst_d;
            mcv_q       <= mcv_d;
            mca_q       <= mca_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            data_q[{lat_idx, cnt_q}] <= mc_rsp_data;
            if (last) tag_q[lat_idx] <= lat_tag;
        end
    end

    assign if_req_ready = ready_q;
    assign if_rsp_valid = rsp_valid_q && !(if_flush && rdy_in);
    assign if_rsp_inst  = rsp_inst_q;
    assign mc_req_valid = mcv_q;
    assign mc_req_addr  = mca_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, conflicts, flush and stall.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        req_v;
    logic [31:0] req_a;
    logic        req_rdy;
    logic        flush;
    logic        rsp_v;
    logic [31:0] rsp_i;
    logic        mreq_v;
    logic [31:0] mreq_a;
    logic        mreq_rdy;
    logic        mrsp_v;
    logic [31:0] mrsp_d;

    int n_chk = 0;
    int n_fail = 0;

    icache dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .rdy_in      (rdy),
        .if_req_valid(req_v),
        .if_req_addr (req_a),
        .if_req_ready(req_rdy),
        .if_flush    (flush),
        .if_rsp_valid(rsp_v),
        .if_rsp_inst (rsp_i),
        .mc_req_valid(mreq_v),
        .mc_req_addr (mreq_a),
        .mc_req_ready(mreq_rdy),
        .mc_rsp_valid(mrsp_v),
        .mc_rsp_data (mrsp_d)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic hit(input logic [31:0] a, input logic [31:0] exp);
        req_v = 1'b1;
        req_a = a;
        step();
        req_v = 1'b0;
        check("hit_v", 32'(rsp_v), 32'd1);
        check("hit_inst", rsp_i, exp);
        check("hit_nomreq", 32'(mreq_v), 32'd0);
    endtask

    task automatic miss(input logic [31:0] a, input logic [31:0] line,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3,
                        input logic [31:0] exp);
        logic [31:0] d [4];
        d = '{d0, d1, d2, d3};
        req_v = 1'b1;
        req_a = a;
        step();
        req_v = 1'b0;
        check("miss_mreq_v", 32'(mreq_v), 32'd1);
        check("miss_mreq_a", mreq_a, line);
        check("miss_rdy_lo", 32'(req_rdy), 32'd0);
        mreq_rdy = 1'b1;
        step();
        mreq_rdy = 1'b0;
        check("miss_mreq_drop", 32'(mreq_v), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mrsp_v = 1'b1;
            mrsp_d = d[i];
            step();
        end
        mrsp_v = 1'b0;
        check("miss_rsp_v", 32'(rsp_v), 32'd1);
        check("miss_rsp_inst", rsp_i, exp);
        step();
        check("miss_rsp_pulse", 32'(rsp_v), 32'd0);
        check("miss_idle_rdy", 32'(req_rdy), 32'd1);
    endtask

    initial begin
        rst_n    = 1'b0;
        rdy      = 1'b1;
        req_v    = 1'b0;
        req_a    = '0;
        flush    = 1'b0;
        mreq_rdy = 1'b0;
        mrsp_v   = 1'b0;
        mrsp_d   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdy", 32'(req_rdy), 32'd0);
        check("rst_rsp_v", 32'(rsp_v), 32'd0);
        check("rst_inst", rsp_i, 32'd0);
        check("rst_mreq_v", 32'(mreq_v), 32'd0);
        check("rst_mreq_a", mreq_a, 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_rdy", 32'(req_rdy), 32'd1);

        // cold miss, then hit
        miss(32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11);
        hit(32'h0, 32'h11);

        // offset select on miss (bypass of last beat) and on hit
        miss(32'h100C, 32'h1000, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA3);
        hit(32'h1004, 32'hA1);

        // conflict on index 0
        miss(32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44, 32'h11);
        miss(32'h400, 32'h400, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB0);
        miss(32'h0, 32'h0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC0);

        // flush mid-fill: line still installed, response squashed
        req_v = 1'b1;
        req_a = 32'h2040;
        step();
        req_v = 1'b0;
        check("f4_mreq_a", mreq_a, 32'h2040);
        mreq_rdy = 1'b1;
        step();
        mreq_rdy = 1'b0;
        mrsp_v = 1'b1;
        mrsp_d = 32'hD0;
        step();
        mrsp_d = 32'hD1;
        step();
        mrsp_v = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        mrsp_v = 1'b1;
        mrsp_d = 32'hD2;
        step();
        mrsp_d = 32'hD3;
        step();
        mrsp_v = 1'b0;
        check("f4_rsp_squashed", 32'(rsp_v), 32'd0);
        step();
        check("f4_rsp_squashed2", 32'(rsp_v), 32'd0);
        check("f4_idle_rdy", 32'(req_rdy), 32'd1);
        hit(32'h2048, 32'hD2);

        // flush in REQ before handshake
        req_v = 1'b1;
        req_a = 32'h3000;
        step();
        req_v = 1'b0;
        check("f5_mreq_v", 32'(mreq_v), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("f5_mreq_drop", 32'(mreq_v), 32'd0);
        check("f5_idle_rdy", 32'(req_rdy), 32'd1);
        check("f5_no_rsp", 32'(rsp_v), 32'd0);
        hit(32'h0, 32'hC0);

        // flush on the hit response cycle
        req_v = 1'b1;
        req_a = 32'h4;
        step();
        req_v = 1'b0;
        flush = 1'b1;
        #1;
        check("fh_rsp_sup", 32'(rsp_v), 32'd0);
        step();
        flush = 1'b0;
        check("fh_after", 32'(rsp_v), 32'd0);

        // flush in the accept cycle drops the request
        req_v = 1'b1;
        req_a = 32'h7000;
        flush = 1'b1;
        step();
        req_v = 1'b0;
        flush = 1'b0;
        check("fa_no_mreq", 32'(mreq_v), 32'd0);
        check("fa_no_rsp", 32'(rsp_v), 32'd0);
        check("fa_rdy", 32'(req_rdy), 32'd1);

        // global stall in REQ and in FILL
        req_v = 1'b1;
        req_a = 32'h5010;
        step();
        req_v = 1'b0;
        rdy = 1'b0;
        mreq_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s6_req_hold_v", 32'(mreq_v), 32'd1);
            check("s6_req_hold_a", mreq_a, 32'h5010);
        end
        rdy = 1'b1;
        step();
        mreq_rdy = 1'b0;
        check("s6_hs", 32'(mreq_v), 32'd0);
        mrsp_v = 1'b1;
        mrsp_d = 32'hE0;
        step();
        mrsp_d = 32'hE1;
        step();
        rdy = 1'b0;
        mrsp_d = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            check("s6_fill_rsp", 32'(rsp_v), 32'd0);
            check("s6_fill_rdy", 32'(req_rdy), 32'd0);
        end
        rdy = 1'b1;
        mrsp_d = 32'hE2;
        step();
        check("s6_not_done", 32'(rsp_v), 32'd0);
        mrsp_d = 32'hE3;
        step();
        mrsp_v = 1'b0;
        check("s6_rsp_v", 32'(rsp_v), 32'd1);
        check("s6_rsp_inst", rsp_i, 32'hE0);
        step();
        hit(32'h501C, 32'hE3);
        hit(32'h5018, 32'hE2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
